// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side access port of the program RAM arbiter
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, rw, adr, wdata, input ack, rdata);
  modport slave  (input req, rw, adr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the program RAM between boot loader (A) and core (B)
// Optional access-conflict counter is built when ARB_STATS_EN is defined.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              boot,
  ram_port_arbiter_if.slave port_a,
  ram_port_arbiter_if.slave port_b,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]        conflict_cnt
`endif
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state;
  logic              gnt;
  logic              last_b;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_adr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;

  logic elig_a;
  logic elig_b;
  logic pick_b;

  // B loses a conflict only when it was the last port served
  assign elig_a = port_a.req;
  assign elig_b = port_b.req & ~boot;
  assign pick_b = elig_b & (~elig_a | ~last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_b    <= 1'b1;
      lat_rw    <= 1'b0;
      lat_adr   <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (elig_a | elig_b) begin
            gnt       <= pick_b;
            last_b    <= pick_b;
            lat_rw    <= pick_b ? port_b.rw    : port_a.rw;
            lat_adr   <= pick_b ? port_b.adr   : port_a.adr;
            lat_wdata <= pick_b ? port_b.wdata : port_a.wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
            if (!lat_rw) begin
              if (gnt) b_rdata <= ram_out;
              else     a_rdata <= ram_out;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (ce && state == IDLE && port_b.req && (port_a.req || boot)
                 && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

  assign ram_enable   = (state == ISSUE) & ce;
  assign ram_rw       = lat_rw;
  assign ram_adr      = lat_adr;
  assign ram_in       = lat_wdata;
  assign port_a.ack   = (state == ACK) & ce & ~gnt;
  assign port_b.ack   = (state == ACK) & ce & gnt;
  assign port_a.rdata = a_rdata;
  assign port_b.rdata = b_rdata;

endmodule
